obstacle_scheduler: RTL
=======================

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter SPAWN_PERIOD, default 60: frame ticks between spawn attempts; legal range 1..255.
REQ-002 Parameter X_MAX, default 608: exclusive upper bound of spawn_x (640 - 32 obstacle width); legal range 512..1023.
REQ-003 Parameter LFSR_SEED, default 10'h1A5: LFSR reset value; SHALL be nonzero.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 enable  input  1  game running; 0 pauses scheduling.
REQ-008 slot_done  input  4  per-slot one-cycle pulse: obstacle in slot i left the screen.
REQ-009 spawn_ready  input  1  obstacle datapath accepts the current offer.
REQ-010 spawn_valid  output  1  spawn offer pending.
REQ-011 spawn_slot  output  2  slot index of the offer.
REQ-012 spawn_x  output  10  start x of the offer, 0..X_MAX-1.
REQ-013 spawn_type  output  2  obstacle type of the offer.
REQ-014 active_mask  output  4  bit i = 1 while slot i holds a live obstacle.
REQ-015 spawn_count  output  16  accepted spawns, saturating at 16'hFFFF.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT, PICK, OFFER.
REQ-017 IDLE: timer held at 0; next state WAIT when enable=1.
REQ-018 WAIT: on frame_tick, timer (8 bit) increments; on frame_tick with timer==SPAWN_PERIOD-1, timer clears to 0 and next state is PICK.
REQ-019 WAIT with enable=0: next state IDLE, timer cleared; active_mask SHALL be retained.
REQ-020 PICK (one cycle): select lowest-index slot with active_mask bit 0; if none free, return to WAIT with no offer (spawn skipped, spawn_count unchanged).
REQ-021 PICK: spawn_x SHALL be v if v < X_MAX else v - X_MAX, where v = LFSR[9:0]; spawn_type SHALL be LFSR[1:0] XOR LFSR[9:8]; both registered and entering OFFER next cycle.
REQ-022 OFFER: spawn_valid=1; spawn_slot, spawn_x, spawn_type SHALL remain stable until the cycle spawn_valid && spawn_ready.
REQ-023 On accept (valid && ready): active_mask[spawn_slot] set, spawn_count incremented (saturating), spawn_valid deasserts next cycle, next state WAIT.
REQ-024 An offer SHALL NOT be withdrawn: enable=0 during OFFER has no effect until accept; state after accept is WAIT, then IDLE if enable still 0.
REQ-025 spawn_valid SHALL be 0 in IDLE, WAIT, PICK.
REQ-026 slot_done[i] SHALL clear active_mask[i] on the next edge in every state; slot_done on an already-clear bit is ignored.
REQ-027 Simultaneous slot_done[j] and accept of slot k (j != k): both SHALL take effect in the same cycle.
REQ-028 PICK SHALL use the registered active_mask; a slot freed by slot_done in the PICK cycle is available from the next attempt.
REQ-029 frame_tick outside WAIT SHALL be ignored (timer does not advance).
REQ-030 LFSR: 10-bit Fibonacci, taps x^10 + x^7 + 1, advances every cycle regardless of state; SHALL never reach 0.

Reset
REQ-031 On reset=1 at a clock edge: state IDLE, timer 0, LFSR = LFSR_SEED, spawn_valid 0, spawn_slot 0, spawn_x 0, spawn_type 0, active_mask 0, spawn_count 0.
REQ-032 Reset SHALL take priority over all inputs, including mid-OFFER and coincident accept.

Verification
REQ-033 SPAWN_PERIOD=3, enable=1, ready=1, frame_tick every 10 cycles -> spawn_valid pulses once per 3 ticks; slots 0,1,2,3 in order; active_mask 4'h1, 4'h3, 4'h7, 4'hF.
REQ-034 All slots active, no slot_done, 5 periods -> no spawn_valid, spawn_count stays 4; then slot_done=4'b0100 -> next offer spawn_slot=2, active_mask 4'hF.
REQ-035 spawn_ready=0 for 20 cycles during OFFER -> spawn_valid, spawn_slot, spawn_x, spawn_type constant for all 20 cycles; ready=1 -> single accept, count +1.
REQ-036 1000 accepted spawns with random slot_done -> every spawn_x in 0..607, LFSR never 0, active_mask matches scoreboard.
REQ-037 reset asserted in the same cycle as valid && ready -> next cycle all outputs per REQ-031, spawn_count 0, active_mask 0.
REQ-038 enable dropped mid-WAIT, then raised -> timer restarts from 0; first offer exactly SPAWN_PERIOD ticks after re-enable; active_mask unchanged across pause.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler.
// Offers a new obstacle every SPAWN_PERIOD frame ticks into the lowest free slot. The offer
// carries a pseudo-random start x and type taken from a free-running 10-bit LFSR. An offer is
// held with a valid/ready handshake and cannot be withdrawn.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   frame_tick            one-cycle pulse per video frame
//   enable                game running; 0 pauses scheduling
//   slot_done[3:0]        per-slot pulse: obstacle in slot i left the screen
//   spawn_ready           datapath accepts the current offer
//   spawn_valid           offer pending
//   spawn_slot[1:0]       slot index of the offer
//   spawn_x[9:0]          start x of the offer, 0..X_MAX-1
//   spawn_type[1:0]       obstacle type of the offer
//   active_mask[3:0]      live-obstacle slots
//   spawn_count[15:0]     accepted spawns, saturating
module obstacle_scheduler #(
  parameter int unsigned SPAWN_PERIOD = 60,
  parameter int unsigned X_MAX        = 608,
  parameter logic [9:0]  LFSR_SEED    = 10'h1A5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [3:0]  slot_done,
  input  logic        spawn_ready,
  output logic        spawn_valid,
  output logic [1:0]  spawn_slot,
  output logic [9:0]  spawn_x,
  output logic [1:0]  spawn_type,
  output logic [3:0]  active_mask,
  output logic [15:0] spawn_count
);

  localparam logic [7:0] PeriodLast = 8'(SPAWN_PERIOD - 1);
  localparam logic [9:0] XMax       = 10'(X_MAX);

  typedef enum logic [1:0] {StIdle, StWait, StPick, StOffer} state_e;

  state_e      state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [9:0]  lfsr_q, lfsr_d;
  logic [1:0]  slot_q, slot_d;
  logic [9:0]  x_q, x_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] count_q, count_d;

  logic        free_found;
  logic [1:0]  free_slot;
  logic [9:0]  lfsr_x;
  logic        accept;

  assign accept = (state_q == StOffer) && spawn_ready;

  // Lowest-index free slot; descending scan so the lowest index is assigned last.
  always_comb begin
    free_found = 1'b0;
    free_slot  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!mask_q[i]) begin
        free_found = 1'b1;
        free_slot  = 2'(i);
      end
    end
  end

  // X_MAX >= 512 guarantees a single subtraction folds any 10-bit value into range.
  assign lfsr_x = (lfsr_q < XMax) ? lfsr_q : (lfsr_q - XMax);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    slot_d  = slot_q;
    x_d     = x_q;
    type_d  = type_q;
    unique case (state_q)
      StIdle: begin
        timer_d = 8'd0;
        if (enable) state_d = StWait;
      end
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
          timer_d = 8'd0;
        end else if (frame_tick) begin
          if (timer_q == PeriodLast) begin
            timer_d = 8'd0;
            state_d = StPick;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
      StPick: begin
        // All slots busy: skip this attempt.
        if (free_found) begin
          slot_d  = free_slot;
          x_d     = lfsr_x;
          type_d  = lfsr_q[1:0] ^ lfsr_q[9:8];
          state_d = StOffer;
        end else begin
          state_d = StWait;
        end
      end
      StOffer: begin
        // enable is deliberately ignored here: an offer is never withdrawn.
        if (spawn_ready) state_d = StWait;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mask_d = mask_q & ~slot_done;
    if (accept) mask_d[slot_q] = 1'b1;
    count_d = count_q;
    if (accept && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
    // Fibonacci x^10 + x^7 + 1.
    lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= 8'd0;
      lfsr_q  <= LFSR_SEED;
      slot_q  <= 2'd0;
      x_q     <= 10'd0;
      type_q  <= 2'd0;
      mask_q  <= 4'd0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lfsr_q  <= lfsr_d;
      slot_q  <= slot_d;
      x_q     <= x_d;
      type_q  <= type_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign spawn_valid = (state_q == StOffer);
  assign spawn_slot  = slot_q;
  assign spawn_x     = x_q;
  assign spawn_type  = type_q;
  assign active_mask = mask_q;
  assign spawn_count = count_q;

endmodule
